// File: rtl/i2cmb_seq_pkg.sv
// Shared constants and types for the iicmb_m_wb transaction sequencer.
package i2cmb_seq_pkg;

  // Controller register map
  localparam int ADR_CSR  = 0;
  localparam int ADR_DPR  = 1;
  localparam int ADR_CMDR = 2;

  // CSR values: core enable + irq enable, and full disable for re-init
  localparam logic [7:0] CSR_ON  = 8'hC0;
  localparam logic [7:0] CSR_OFF = 8'h00;

  typedef enum logic [2:0] {
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110
  } cmd_e;

  // CMDR response bits
  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL  = 5;
  localparam int CMDR_ERR = 4;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NAK      = 3'd1,
    ST_ARB_LOST = 3'd2,
    ST_ERR      = 3'd3,
    ST_TIMEOUT  = 3'd4
  } status_e;

  typedef enum logic [4:0] {
    S_INIT, S_IDLE, S_BUS_DPR, S_BUS_CMD, S_START, S_ADR_DPR, S_ADR_CMD,
    S_WAIT, S_RD_CMDR, S_BYTE, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR,
    S_STOP, S_TO_CSR, S_DONE, S_FIN
  } state_e;

endpackage

// File: rtl/i2cmb_wb_master_port.sv
// Single-access Wishbone master: launches one cycle on start, holds it
// until ack_i, then drops everything on the following edge.
module i2cmb_wb_master_port #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start,
  input  logic                     we,
  input  logic [WB_ADDR_WIDTH-1:0] adr,
  input  logic [WB_DATA_WIDTH-1:0] wdat,
  output logic                     busy,
  output logic [WB_DATA_WIDTH-1:0] rdat,
  output logic                     ack,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i
);

  // ack is the ack_i cycle itself so the caller can capture dat_i there
  assign busy = cyc_o;
  assign ack  = cyc_o & ack_i;
  assign rdat = dat_i;

  // Bus cycle register: launch on start, release on the ack edge
  always_ff @(posedge clk_i) begin
    if (rst_i || (cyc_o && ack_i)) begin
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
    end else if (start && !cyc_o) begin
      cyc_o <= 1'b1;
      stb_o <= 1'b1;
      we_o  <= we;
      adr_o <= adr;
      dat_o <= we ? wdat : '0;
    end
  end

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// Turns one byte-level I2C request into the iicmb_m_wb register sequence:
// set bus, START, address, data bytes, STOP, waiting on irq between commands.
module i2cmb_wb_sequencer
  import i2cmb_seq_pkg::*;
#(
  parameter int NUM_BUSSES    = 16,
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int IRQ_TIMEOUT   = 1_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_bus,
  input  logic [6:0]               req_addr,
  input  logic                     req_rw,
  input  logic [7:0]               req_len,
  input  logic                     wdata_valid,
  input  logic [7:0]               wdata,
  output logic                     wdata_ready,
  output logic                     rdata_valid,
  output logic [7:0]               rdata,
  output logic                     done,
  output logic [2:0]               status,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  // Out-of-range bus ids are passed through; the controller reports ERR
  if (NUM_BUSSES < 1 || NUM_BUSSES > 16) begin : g_bad_num_busses
    $error("NUM_BUSSES must be 1..16");
  end

  state_e  state, ret_st;
  status_e st_w;
  logic [TW-1:0] tcnt;
  logic [3:0] bus_q;
  logic [6:0] addr_q;
  logic       rw_q, last_q, pend, start, reinit;
  logic [7:0] cnt_q, dreg;

  logic                     acc, a_we, busy, ack, hit;
  logic [WB_ADDR_WIDTH-1:0] a_adr;
  logic [WB_DATA_WIDTH-1:0] a_dat, rdat;

  i2cmb_wb_master_port #(.WB_ADDR_WIDTH(WB_ADDR_WIDTH), .WB_DATA_WIDTH(WB_DATA_WIDTH)) u_port (
    .clk_i(clk_i), .rst_i(rst_i), .start(start), .we(a_we), .adr(a_adr), .wdat(a_dat),
    .busy(busy), .rdat(rdat), .ack(ack),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  assign hit = pend & ack;

  // Which register access (if any) the current state performs
  always_comb begin
    acc   = 1'b1;
    a_we  = 1'b1;
    a_adr = WB_ADDR_WIDTH'(ADR_CMDR);
    a_dat = '0;
    case (state)
      S_INIT:    begin a_adr = WB_ADDR_WIDTH'(ADR_CSR); a_dat = WB_DATA_WIDTH'(CSR_ON);  end
      S_TO_CSR:  begin a_adr = WB_ADDR_WIDTH'(ADR_CSR); a_dat = WB_DATA_WIDTH'(CSR_OFF); end
      S_BUS_DPR: begin a_adr = WB_ADDR_WIDTH'(ADR_DPR); a_dat = WB_DATA_WIDTH'(bus_q); end
      S_BUS_CMD: a_dat = WB_DATA_WIDTH'(CMD_SET_BUS);
      S_START:   a_dat = WB_DATA_WIDTH'(CMD_START);
      S_ADR_DPR: begin a_adr = WB_ADDR_WIDTH'(ADR_DPR); a_dat = WB_DATA_WIDTH'({addr_q, rw_q}); end
      S_ADR_CMD: a_dat = WB_DATA_WIDTH'(CMD_WRITE);
      S_WR_DPR:  begin a_adr = WB_ADDR_WIDTH'(ADR_DPR); a_dat = WB_DATA_WIDTH'(dreg); end
      S_WR_CMD:  a_dat = WB_DATA_WIDTH'(CMD_WRITE);
      S_RD_CMD:  a_dat = last_q ? WB_DATA_WIDTH'(CMD_READ_NAK) : WB_DATA_WIDTH'(CMD_READ_ACK);
      S_STOP:    a_dat = WB_DATA_WIDTH'(CMD_STOP);
      S_RD_CMDR: a_we  = 1'b0;
      S_RD_DPR:  begin a_we = 1'b0; a_adr = WB_ADDR_WIDTH'(ADR_DPR); end
      default:   acc   = 1'b0;
    endcase
  end

  // Main sequencer: issues one access per state, waits on irq between commands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_INIT;     ret_st <= S_INIT;   st_w <= ST_OK;
      tcnt <= '0;          pend <= 1'b0;       start <= 1'b0;   reinit <= 1'b0;
      bus_q <= '0;         addr_q <= '0;       rw_q <= 1'b0;    last_q <= 1'b0;
      cnt_q <= '0;         dreg <= '0;
      req_ready <= 1'b0;   wdata_ready <= 1'b0; rdata_valid <= 1'b0; rdata <= '0;
      done <= 1'b0;        status <= '0;
    end else begin
      start       <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      if (state != S_WAIT) tcnt <= '0;
      if (acc && !pend && !busy) begin start <= 1'b1; pend <= 1'b1; end
      if (hit) pend <= 1'b0;
      case (state)
        S_INIT:    if (hit) begin state <= S_IDLE; req_ready <= 1'b1; end
        S_IDLE:    if (req_valid && req_ready) begin
                     bus_q <= req_bus; addr_q <= req_addr; rw_q <= req_rw; cnt_q <= req_len;
                     st_w <= ST_OK; req_ready <= 1'b0; state <= S_BUS_DPR;
                   end
        S_BUS_DPR: if (hit) state <= S_BUS_CMD;
        S_BUS_CMD: if (hit) begin state <= S_WAIT; ret_st <= S_START; end
        S_START:   if (hit) begin state <= S_WAIT; ret_st <= S_ADR_DPR; end
        S_ADR_DPR: if (hit) state <= S_ADR_CMD;
        S_ADR_CMD: if (hit) begin state <= S_WAIT; ret_st <= S_BYTE; end
        S_WR_DPR:  if (hit) state <= S_WR_CMD;
        S_WR_CMD:  if (hit) begin state <= S_WAIT; ret_st <= S_BYTE; end
        S_RD_CMD:  if (hit) begin state <= S_WAIT; ret_st <= S_RD_DPR; end
        S_STOP:    if (hit) begin state <= S_WAIT; ret_st <= S_DONE; end
        S_TO_CSR:  if (hit) state <= S_DONE;
        S_RD_DPR:  if (hit) begin rdata <= rdat[7:0]; rdata_valid <= 1'b1; state <= S_BYTE; end
        S_WAIT: begin
          if (irq_i) state <= S_RD_CMDR;
          else if (tcnt == TW'(IRQ_TIMEOUT - 1)) begin
            st_w <= ST_TIMEOUT; reinit <= 1'b1; state <= S_TO_CSR;
          end else tcnt <= tcnt + 1'b1;
        end
        // STOP completion always finishes; otherwise errors win over DON
        S_RD_CMDR: if (hit) begin
          if (ret_st == S_DONE)    state <= S_DONE;
          else if (rdat[CMDR_AL])  begin st_w <= ST_ARB_LOST; state <= S_DONE; end
          else if (rdat[CMDR_ERR]) begin st_w <= ST_ERR;      state <= S_DONE; end
          else if (rdat[CMDR_NAK]) begin st_w <= ST_NAK;      state <= S_STOP; end
          else if (rdat[CMDR_DON]) state <= ret_st;
          else                     begin st_w <= ST_ERR;      state <= S_DONE; end
        end
        S_BYTE: begin
          if (cnt_q == 8'd0) state <= S_STOP;
          else if (rw_q) begin
            last_q <= (cnt_q == 8'd1); cnt_q <= cnt_q - 8'd1; state <= S_RD_CMD;
          end else if (wdata_valid) begin
            wdata_ready <= 1'b1; dreg <= wdata; cnt_q <= cnt_q - 8'd1; state <= S_WR_DPR;
          end
        end
        S_DONE:    begin done <= 1'b1; status <= st_w; state <= S_FIN; end
        S_FIN:     if (reinit) begin reinit <= 1'b0; state <= S_INIT; end
                   else begin req_ready <= 1'b1; state <= S_IDLE; end
        default:   state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench: behavioural iicmb_m_wb register model plus hand-computed
// register-write sequences, read data and status per transaction.
module tb_i2cmb_wb_sequencer;

  logic       clk = 1'b0, rst_i = 1'b1;
  logic       req_valid = 1'b0, req_rw = 1'b0, wdata_valid = 1'b0;
  logic [3:0] req_bus = '0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_len = '0, wdata = '0;
  logic       req_ready, wdata_ready, rdata_valid, done;
  logic [7:0] rdata;
  logic [2:0] status;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack_i = 1'b0, irq_i = 1'b0;

  i2cmb_wb_sequencer #(.NUM_BUSSES(16), .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .IRQ_TIMEOUT(100)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .status(status),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [9:0] wb_log[$];      // {adr, dat} of every register write
  logic [9:0] expq[$];
  logic [7:0] rd_got[$];
  int done_cnt = 0, wrdy_cnt = 0, rd_idx = 0, irq_cnt = 0;
  logic [2:0] last_st = '0;
  logic [7:0] resp = 8'h80;
  logic nak_addr = 1'b0, irq_off = 1'b0, addr_phase = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: one-cycle ack, irq three cycles after any command,
  // CMDR read clears irq; NAK on the address byte when nak_addr is set.
  always @(negedge clk) begin
    if (rst_i) begin
      ack_i = 1'b0; irq_i = 1'b0; irq_cnt = 0; addr_phase = 1'b0;
    end else begin
      if (ack_i) ack_i = 1'b0;
      else if (cyc_o && stb_o) begin
        if (we_o) begin
          wb_log.push_back({adr_o, dat_o});
          if (adr_o == 2'd2) begin
            if (dat_o[2:0] == 3'b001 && addr_phase) begin
              resp = nak_addr ? 8'hC0 : 8'h80; addr_phase = 1'b0;
            end else resp = 8'h80;
            if (dat_o[2:0] == 3'b100) addr_phase = 1'b1;
            if (!irq_off) irq_cnt = 3;
          end
        end else if (adr_o == 2'd2) begin
          dat_i = resp; irq_i = 1'b0;
        end else begin
          dat_i = 8'h10 + 8'(rd_idx); rd_idx++;
        end
        ack_i = 1'b1;
      end
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) irq_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin done_cnt++; last_st = status; end
    if (rdata_valid) rd_got.push_back(rdata);
    if (wdata_ready) wrdy_cnt++;
  end

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, wb_log.size(), expq.size());
    foreach (expq[i])
      chk($sformatf("%s_w%0d", tag, i), (i < wb_log.size()) ? 32'(wb_log[i]) : 32'hFFFF, 32'(expq[i]));
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic send_req(input logic [3:0] b, input logic [6:0] a, input logic rw, input logic [7:0] len);
    wait_ready("req");
    req_bus = b; req_addr = a; req_rw = rw; req_len = len; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    int d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    if (done_cnt == d0) chk("done_wait", 32'd0, 32'd1);
  endtask

  task automatic feed2(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] bs [2];
    bs[0] = b0; bs[1] = b1;
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      wdata_valid = 1'b1; wdata = bs[i];
      @(negedge clk);
      while (!wdata_ready && k < 500) begin @(negedge clk); k++; end
      chk($sformatf("wdata_ready_%0d", i), wdata_ready, 1'b1);
    end
    wdata_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state and one-time controller enable
    repeat (3) @(negedge clk);
    chk("reset_outs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wdata_ready, rdata_valid, rdata, done, status}, 32'd0);
    rst_i = 1'b0;
    wait_ready("init");
    expq = '{10'h0C0};
    check_seq("init");
    repeat (20) @(negedge clk);
    chk("init_quiet", wb_log.size(), 32'd1);

    // Two-byte write
    wb_log.delete();
    send_req(4'd0, 7'h22, 1'b0, 8'd2);
    fork
      feed2(8'hA5, 8'h5A);
      wait_done(1000, n);
    join
    expq = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h1A5, 10'h201, 10'h15A, 10'h201, 10'h205};
    check_seq("wr2");
    chk("wr2_status", last_st, 3'd0);

    // Three-byte read: ACK, ACK, NAK
    wb_log.delete(); rd_got.delete(); rd_idx = 0;
    send_req(4'd0, 7'h22, 1'b1, 8'd3);
    wait_done(1000, n);
    expq = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h202, 10'h202, 10'h203, 10'h205};
    check_seq("rd3");
    chk("rd3_cnt", rd_got.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rd3_b%0d", i), (i < rd_got.size()) ? 32'(rd_got[i]) : 32'hFFFF, 32'h10 + 32'(i));
    chk("rd3_status", last_st, 3'd0);

    // Address-only probe
    wb_log.delete();
    send_req(4'd3, 7'h22, 1'b0, 8'd0);
    wait_done(500, n);
    expq = '{10'h103, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205};
    check_seq("probe");
    chk("probe_status", last_st, 3'd0);

    // Address NAK: STOP follows, no data phase even with data offered
    wb_log.delete(); nak_addr = 1'b1; wrdy_cnt = 0;
    wdata_valid = 1'b1; wdata = 8'h77;
    send_req(4'd0, 7'h22, 1'b0, 8'd2);
    wait_done(500, n);
    wdata_valid = 1'b0; nak_addr = 1'b0;
    expq = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205};
    check_seq("nak");
    chk("nak_status", last_st, 3'd1);
    chk("nak_no_wdata", wrdy_cnt, 32'd0);

    // Reset during the START wait: no STOP, outputs cleared, re-init
    wb_log.delete();
    send_req(4'd0, 7'h22, 1'b0, 8'd0);
    n = 0;
    while (wb_log.size() < 3 && n < 300) begin @(negedge clk); n++; end
    chk("rst_reach_start", wb_log.size(), 32'd3);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wdata_ready, rdata_valid, rdata, done, status}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    wait_ready("rst_mid");
    expq = '{10'h100, 10'h206, 10'h204, 10'h0C0};
    check_seq("rst_mid");

    // irq never arrives: timeout, CSR disabled, then re-enabled
    wb_log.delete(); irq_off = 1'b1;
    send_req(4'd0, 7'h22, 1'b0, 8'd0);
    wait_done(400, n);
    chk("to_status", last_st, 3'd4);
    chk("to_latency", (n >= 100 && n <= 140) ? 32'd1 : 32'd0, 32'd1);
    wait_ready("to");
    irq_off = 1'b0;
    expq = '{10'h100, 10'h206, 10'h000, 10'h0C0};
    check_seq("to");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
